// File: rtl/mul_seq_pkg.sv
// Shared definitions for the execute-stage multiply sequencer: ALU control
// codes, sequencer state encoding and the multiply-code decode helper.
package mul_seq_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_MUL  = 4'b1110;
    localparam logic [3:0] ALU_MULH = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic is_mul_code(input logic [3:0] code);
        return (code == ALU_MUL) || (code == ALU_MULH);
    endfunction

endpackage

// File: rtl/mul_seq_datapath.sv
// Shift-add multiply datapath: operand capture with magnitude conversion,
// one WIDTH+1-bit adder, right shifter, and final sign fix into the result.
module mul_seq_datapath
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic             is_mulh,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result
);

    logic               mulh_q;
    logic               neg_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   result_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;

    // Negating the most-negative value wraps to itself, which read as
    // unsigned is exactly 2^(WIDTH-1) -- the magnitude we want.
    assign a_mag   = (is_mulh && op_a[WIDTH-1]) ? -op_a : op_a;
    assign b_mag   = (is_mulh && op_b[WIDTH-1]) ? -op_b : op_b;

    assign addend  = mplier_q[0] ? {1'b0, mcand_q} : '0;
    assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend;
    assign product = (mulh_q && neg_q) ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mulh_q   <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (load) begin
            mulh_q   <= is_mulh;
            neg_q    <= is_mulh && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            acc_q    <= '0;
        end else if (step) begin
            // The adder carry becomes the new accumulator MSB as we shift.
            acc_q    <= {sum, acc_q[WIDTH-1:1]};
            mplier_q <= mplier_q >> 1;
        end else if (finish) begin
            result_q <= mulh_q ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
        end
    end

    assign result = result_q;

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle MUL/MULH sequencer: accepts a request from IDLE, runs WIDTH
// shift-add iterations, one sign-fix cycle, then pulses done with the result.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic          done_q;
    logic          req_valid;
    logic          accept;

    assign req_valid = start && is_mul_code(alu_ctrl);
    assign accept    = (state_q == ST_IDLE) && req_valid && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= ST_IDLE;
                count_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            state_q <= ST_CALC;
                            count_q <= '0;
                        end
                    end
                    ST_CALC: begin
                        count_q <= count_q + CW'(1);
                        if (count_q == LAST) state_q <= ST_FIX;
                    end
                    ST_FIX: begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign stall = ((state_q == ST_IDLE) && req_valid) || busy;
    assign done  = done_q;

    mul_seq_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .step    ((state_q == ST_CALC) && !flush),
        .finish  ((state_q == ST_FIX) && !flush),
        .is_mulh (alu_ctrl == ALU_MULH),
        .op_a    (op_a),
        .op_b    (op_b),
        .result  (result)
    );

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed vector table, random operations
// against an arithmetic reference, and hand-written flush/reset/handshake cases.
module tb_mul_seq;

    localparam int         WIDTH  = 32;
    localparam logic [3:0] C_MUL  = 4'b1110;
    localparam logic [3:0] C_MULH = 4'b1111;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [3:0] ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[8];

    mul_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit products.
    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        if (c == C_MULH) begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return sp[63:32];
        end
        up = {32'd0, a} * {32'd0, b};
        return up[31:0];
    endfunction

    // Called positioned at a falling edge; returns at the falling edge of the done cycle.
    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        int win_err;
        bit seen;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        start    = 1'b1;
        #1;
        check({name, " stall_on_req"}, 64'(stall), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        win_err = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (!busy || !stall) win_err++;
        end
        check({name, " latency"}, 64'(n), 64'd33);
        check({name, " busy_window"}, 64'(win_err), 64'd0);
        check({name, " result"}, 64'(result), 64'(exp));
        check({name, " idle_at_done"}, {62'd0, busy, stall}, 64'd0);
    endtask

    initial begin
        int dn;
        int spurious;
        logic [31:0] prior;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rc;

        tbl[0] = '{"mul_7x6",       C_MUL,  32'd7,        32'd6,        32'd42};
        tbl[1] = '{"mulh_m1x2",     C_MULH, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        tbl[2] = '{"mulh_max_sq",   C_MULH, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
        tbl[3] = '{"mulh_min_sq",   C_MULH, 32'h80000000, 32'h80000000, 32'h40000000};
        tbl[4] = '{"mul_min_sq",    C_MUL,  32'h80000000, 32'h80000000, 32'h00000000};
        tbl[5] = '{"mul_m1xm1",     C_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        tbl[6] = '{"mulh_min_x_m1", C_MULH, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        tbl[7] = '{"mulh_min_x_1",  C_MULH, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};

        rst_n = 1'b0; start = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {busy, stall, done, 29'd0, result}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].name, tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].exp);
            @(negedge clk);
            check({tbl[i].name, " done_one_cycle"}, 64'(done), 64'd0);
        end

        // Invalid control code is not a request.
        alu_ctrl = 4'b0000; op_a = 32'd3; op_b = 32'd4; start = 1'b1;
        #1 check("invalid stall", 64'(stall), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("invalid busy", {62'd0, busy, done}, 64'd0);
        start = 1'b0;

        // Flush at the 10th CALC cycle.
        prior = result;
        alu_ctrl = C_MUL; op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("flush pre busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush busy drop", {62'd0, busy, done}, 64'd0);
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        check("flush no done", 64'(spurious), 64'd0);
        check("flush result kept", 64'(result), 64'(prior));
        run_op("after_flush", C_MUL, 32'd1234, 32'd5678, model(C_MUL, 32'd1234, 32'd5678));
        @(negedge clk);

        // Start held through the whole operation: one done only.
        alu_ctrl = C_MULH; op_a = 32'hFFFFFFF9; op_b = 32'd6; start = 1'b1;
        @(posedge clk);
        dn = 0;
        for (int i = 0; i < 40 && dn == 0; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        start = 1'b0;
        check("held result", 64'(result), 64'(model(C_MULH, 32'hFFFFFFF9, 32'd6)));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("held one done", 64'(dn), 64'd1);

        // Back-to-back: second request issued in the done cycle.
        run_op("b2b_first", C_MUL, 32'd100, 32'd200, 32'd20000);
        run_op("b2b_second", C_MULH, 32'h12345678, 32'h9ABCDEF0,
               model(C_MULH, 32'h12345678, 32'h9ABCDEF0));
        @(negedge clk);

        // Asynchronous reset mid-CALC.
        alu_ctrl = C_MUL; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async reset outputs", {busy, stall, done, 29'd0, result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post reset idle", {62'd0, busy, done}, 64'd0);
        run_op("after_reset", C_MUL, 32'd9, 32'd9, 32'd81);

        // Random operations against the arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            rc = ($urandom_range(0, 1) == 0) ? C_MUL : C_MULH;
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) ra = 32'h80000000;
            if (i % 7 == 0) rb = 32'hFFFFFFFF;
            run_op($sformatf("rand%0d", i), rc, ra, rb, model(rc, ra, rb));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle sequencer for the MUL/MULH operations of the execute stage. Accepts a multiply request carrying the 4-bit ALU control code, runs a radix-2 shift-add loop over a single adder, applies sign correction for MULH, and returns one registered result with a done pulse. Drives the pipeline stall while the operation is in flight; sits beside the ALU and is selected when the ALU control lines decode to a multiply.

## Interface

- WIDTH, 32: operand and result width (≥ 4, even)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- alu_ctrl  in  4  ALU control lines: 4'b1110 = MUL (low word), 4'b1111 = MULH (signed×signed, high word); other codes are not requests
- op_a  in  WIDTH  rs1 operand, sampled on accept
- op_b  in  WIDTH  rs2 operand, sampled on accept
- flush  in  1  pipeline kill; aborts any operation in flight
- busy  out  1  operation in flight (CALC or FIX)
- stall  out  1  pipeline stall = (IDLE & start & valid code) | busy; combinational
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  product word, held until next done

## Operation

- Reset: state IDLE, busy 0, done 0, result 0, counter 0, accumulator 0, all internal operand registers 0.
- States: IDLE → CALC → FIX → IDLE.
- IDLE: accept when start=1, alu_ctrl ∈ {1110,1111}, flush=0. On accept register: op code, multiplicand/multiplier. MUL: operands as given (low word independent of signedness). MULH: absolute values of op_a, op_b; neg flag = op_a[MSB] ^ op_b[MSB]. Clear 2·WIDTH accumulator, counter ← 0.
- Invalid code with start=1: ignored, no stall, stays IDLE.
- CALC: each cycle, if multiplier LSB=1 add multiplicand into accumulator upper half; shift accumulator/multiplier right 1 (carry kept, WIDTH+1-bit adder). Counter increments; after WIDTH iterations → FIX.
- FIX: if MULH and neg, negate 2·WIDTH product (two's complement). result ← low word (MUL) or high word (MULH); done ← 1; → IDLE.
- Absolute value of most-negative operand: treat as unsigned 2^(WIDTH-1); MULH(0x80000000, 0x80000000) = 0x40000000.
- start while busy: ignored (not queued).
- flush in any state: → IDLE next edge, busy 0, done not asserted, result unchanged. flush takes precedence over accept and over FIX completion.
- Reset mid-operation: immediate return to reset values.

## Timing

- Accept at edge k (IDLE, start valid). stall=1 combinationally in cycle before edge k.
- busy=1 cycles k+1 … k+WIDTH+1 (WIDTH CALC cycles, 1 FIX cycle).
- done=1 and result valid in cycle after edge k+WIDTH+1; latency WIDTH+1 cycles edge-to-done (33 for WIDTH=32). stall low in the done cycle.
- Back-to-back: new start may be accepted in the done cycle (state is IDLE).
- done never asserts for two consecutive cycles.

## Structure

- Shared package: ALU control code constants (ADD 0000 … MUL 1110, MULH 1111) and state encoding typedef; ALU control decoder uses the same constants.
- One natural sub-module: mul_seq_datapath (accumulator, adder, shifter, negate), with mul_seq holding FSM and counter.

## Test plan

- MUL 7×6, WIDTH=32 → done 33 cycles after accept, result 42; stall high from start cycle through last busy cycle.
- MULH 0xFFFFFFFF×0x00000002 (−1×2) → result 0xFFFFFFFF; MULH 0x7FFFFFFF×0x7FFFFFFF → 0x3FFFFFFF.
- MULH 0x80000000×0x80000000 → 0x40000000; MUL same → 0x00000000.
- flush at CALC cycle 10 → busy drops next cycle, no done, result keeps prior value; new start then accepted normally.
- start with alu_ctrl=0000 → no accept, stall 0; start held during busy → exactly one done; back-to-back start in done cycle → second done 33 cycles later.
- rst_n low mid-CALC → all outputs 0 immediately (async), IDLE after release.
